// File: rtl/rf_pkg.sv
// Shared constants and payload type for the register-file writeback path.
// No ports: compile-time parameters only.
package rf_pkg;

    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;
    localparam int unsigned CW   = 2;

    localparam logic [AW-1:0] REG_ZERO = '0;
    localparam logic [CW-1:0] CNT_MAX  = '1;

    // One writeback request: destination register and value.
    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write scoreboard with saturating counters.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   rsv_valid_i, rsv_a_i     issue-stage reservation of a destination register
//   rsv_ready_o              reservation can be accepted (counter not saturated)
//   rel_valid_i, rel_a_i     granted writeback releasing one pending write
//   chk_a1_i, chk_a2_i       read addresses to check for RAW hazards
//   hazard1_o, hazard2_o     read address has at least one pending write
//   sb_err_o                 sticky: release seen on a register with nothing pending
module rf_scoreboard
    import rf_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rsv_valid_i,
    input  logic [AW-1:0] rsv_a_i,
    output logic          rsv_ready_o,
    input  logic          rel_valid_i,
    input  logic [AW-1:0] rel_a_i,
    input  logic [AW-1:0] chk_a1_i,
    input  logic [AW-1:0] chk_a2_i,
    output logic          hazard1_o,
    output logic          hazard2_o,
    output logic          sb_err_o
);

    logic [CW-1:0]   cnt_q [NREG];
    logic [CW-1:0]   cnt_d [NREG];
    logic            sb_err_q;
    logic            sb_err_d;
    logic            rsv_fire;
    logic            rel_fire;
    logic [NREG-1:0] inc_hit;
    logic [NREG-1:0] rel_hit;

    // Saturation check only; a same-cycle release is deliberately not looked ahead.
    assign rsv_ready_o = (cnt_q[rsv_a_i] != CNT_MAX);
    assign rsv_fire    = rsv_valid_i && rsv_ready_o && (rsv_a_i != REG_ZERO);
    assign rel_fire    = rel_valid_i && (rel_a_i != REG_ZERO);

    assign hazard1_o = (chk_a1_i != REG_ZERO) && (cnt_q[chk_a1_i] != '0);
    assign hazard2_o = (chk_a2_i != REG_ZERO) && (cnt_q[chk_a2_i] != '0);
    assign sb_err_o  = sb_err_q;

    // Counter update: reserve and release on the same register cancel out.
    always_comb begin
        cnt_d   = cnt_q;
        inc_hit = '0;
        rel_hit = '0;
        for (int unsigned i = 1; i < NREG; i++) begin
            inc_hit[i] = rsv_fire && (rsv_a_i == AW'(i));
            rel_hit[i] = rel_fire && (rel_a_i == AW'(i));
            if (inc_hit[i] && !rel_hit[i]) begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end else if (rel_hit[i] && !inc_hit[i] && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - CW'(1);
            end
        end
        cnt_d[0] = '0;
        sb_err_d = sb_err_q | (rel_fire && (cnt_q[rel_a_i] == '0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                cnt_q[i] <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sb_err_q <= sb_err_d;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register file's single write port between
// the ALU pipe (req0) and the multi-cycle unit (req1), plus RAW scoreboard.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   req0_valid/ready/a/data           ALU writeback handshake
//   req1_valid/ready/a/data           mul/div/load writeback handshake
//   rsv_valid/ready/a                 destination reservation from issue
//   chk_a1, chk_a2 -> hazard1, hazard2 RAW hazard check on read addresses
//   write_en/write_a/write_data       registered register-file write port
//   sb_err                            sticky scoreboard underflow flag
module rf_wb_arbiter
    import rf_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [AW-1:0] req0_a,
    input  logic [DW-1:0] req0_data,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [AW-1:0] req1_a,
    input  logic [DW-1:0] req1_data,
    input  logic          rsv_valid,
    output logic          rsv_ready,
    input  logic [AW-1:0] rsv_a,
    input  logic [AW-1:0] chk_a1,
    input  logic [AW-1:0] chk_a2,
    output logic          hazard1,
    output logic          hazard2,
    output logic          write_en,
    output logic [AW-1:0] write_a,
    output logic [DW-1:0] write_data,
    output logic          sb_err
);

    logic          last_grant_q, last_grant_d;
    logic          write_en_q, write_en_d;
    logic [AW-1:0] write_a_q, write_a_d;
    logic [DW-1:0] write_data_q, write_data_d;
    logic          grant0, grant1, grant_any;
    wb_req_t       win;

    // Grant and next-state: on a tie the requester that did not win last goes.
    always_comb begin
        grant0       = req0_valid && (!req1_valid || last_grant_q);
        grant1       = req1_valid && (!req0_valid || !last_grant_q);
        grant_any    = grant0 || grant1;
        win          = grant1 ? wb_req_t'{a: req1_a, data: req1_data}
                              : wb_req_t'{a: req0_a, data: req0_data};
        last_grant_d = last_grant_q;
        write_en_d   = 1'b0;
        write_a_d    = write_a_q;
        write_data_d = write_data_q;
        if (grant_any) begin
            last_grant_d = grant1;
            write_a_d    = win.a;
            write_data_d = win.data;
            // Writes to R0 are consumed but never reach the register file.
            write_en_d   = (win.a != REG_ZERO);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            write_en_q   <= 1'b0;
            write_a_q    <= '0;
            write_data_q <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            write_en_q   <= write_en_d;
            write_a_q    <= write_a_d;
            write_data_q <= write_data_d;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign write_en   = write_en_q;
    assign write_a    = write_a_q;
    assign write_data = write_data_q;

    rf_scoreboard u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .rsv_valid_i (rsv_valid),
        .rsv_a_i     (rsv_a),
        .rsv_ready_o (rsv_ready),
        .rel_valid_i (grant_any),
        .rel_a_i     (win.a),
        .chk_a1_i    (chk_a1),
        .chk_a2_i    (chk_a2),
        .hazard1_o   (hazard1),
        .hazard2_o   (hazard2),
        .sb_err_o    (sb_err)
    );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter.
module tb_rf_wb_arbiter;
    import rf_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req0_ready;
    logic [AW-1:0] req0_a;
    logic [DW-1:0] req0_data;
    logic          req1_valid, req1_ready;
    logic [AW-1:0] req1_a;
    logic [DW-1:0] req1_data;
    logic          rsv_valid, rsv_ready;
    logic [AW-1:0] rsv_a;
    logic [AW-1:0] chk_a1, chk_a2;
    logic          hazard1, hazard2;
    logic          write_en;
    logic [AW-1:0] write_a;
    logic [DW-1:0] write_data;
    logic          sb_err;

    int n_checks = 0;
    int n_fails  = 0;

    rf_wb_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_data  (req1_data),
        .rsv_valid  (rsv_valid),
        .rsv_ready  (rsv_ready),
        .rsv_a      (rsv_a),
        .chk_a1     (chk_a1),
        .chk_a2     (chk_a2),
        .hazard1    (hazard1),
        .hazard2    (hazard2),
        .write_en   (write_en),
        .write_a    (write_a),
        .write_data (write_data),
        .sb_err     (sb_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reserve(input logic [AW-1:0] a);
        rsv_valid = 1'b1;
        rsv_a     = a;
        tick();
        rsv_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_data = '0;
        req1_valid = 1'b0; req1_a = '0; req1_data = '0;
        rsv_valid  = 1'b0; rsv_a  = '0;
        chk_a1 = 5'd5; chk_a2 = 5'd0;
        #12;
        check_eq("rst_write_en",   32'(write_en),   32'd0);
        check_eq("rst_write_a",    32'(write_a),    32'd0);
        check_eq("rst_write_data", write_data,      32'd0);
        check_eq("rst_sb_err",     32'(sb_err),     32'd0);
        check_eq("rst_hazard1",    32'(hazard1),    32'd0);
        check_eq("rst_rsv_ready",  32'(rsv_ready),  32'd1);
        rst_n = 1'b1;
        tick();

        // Single ALU writeback to reserved R5.
        reserve(5'd5);
        #1;
        check_eq("t1_hazard_pre", 32'(hazard1), 32'd1);
        req0_valid = 1'b1; req0_a = 5'd5; req0_data = 32'hDEADBEEF;
        #1;
        check_eq("t1_req0_ready", 32'(req0_ready), 32'd1);
        check_eq("t1_req1_ready", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        check_eq("t1_write_en",   32'(write_en), 32'd1);
        check_eq("t1_write_a",    32'(write_a),  32'd5);
        check_eq("t1_write_data", write_data,    32'hDEADBEEF);
        check_eq("t1_hazard_post", 32'(hazard1), 32'd0);
        tick();
        check_eq("t1_idle_write_en", 32'(write_en), 32'd0);
        check_eq("t1_idle_write_a",  32'(write_a),  32'd5);

        // Both requesters held valid for four cycles: strict alternation from reset.
        pulse_reset();
        tick();
        reserve(5'd3); reserve(5'd3); reserve(5'd4); reserve(5'd4);
        chk_a1 = 5'd3; chk_a2 = 5'd4;
        req0_valid = 1'b1; req0_a = 5'd3; req0_data = 32'hA0A0_0003;
        req1_valid = 1'b1; req1_a = 5'd4; req1_data = 32'hB1B1_0004;
        for (int k = 0; k < 4; k++) begin
            logic exp_r0;
            exp_r0 = (k % 2 == 0);
            #1;
            check_eq($sformatf("t2_req0_ready_%0d", k), 32'(req0_ready), 32'(exp_r0));
            check_eq($sformatf("t2_req1_ready_%0d", k), 32'(req1_ready), 32'(!exp_r0));
            tick();
            check_eq($sformatf("t2_write_en_%0d", k), 32'(write_en), 32'd1);
            check_eq($sformatf("t2_write_a_%0d", k), 32'(write_a), exp_r0 ? 32'd3 : 32'd4);
            check_eq($sformatf("t2_write_data_%0d", k), write_data,
                     exp_r0 ? 32'hA0A0_0003 : 32'hB1B1_0004);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        check_eq("t2_hazard1_clear", 32'(hazard1), 32'd0);
        check_eq("t2_hazard2_clear", 32'(hazard2), 32'd0);
        check_eq("t2_sb_err",        32'(sb_err),  32'd0);

        // Saturate R7 (three reservations), then release one.
        chk_a1 = 5'd7;
        for (int k = 0; k < 3; k++) begin
            rsv_valid = 1'b1; rsv_a = 5'd7;
            #1;
            check_eq($sformatf("t3_rsv_ready_%0d", k), 32'(rsv_ready), 32'd1);
            tick();
        end
        #1;
        check_eq("t3_rsv_ready_full", 32'(rsv_ready), 32'd0);
        tick();
        rsv_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 5'd7; req1_data = 32'h0000_0777;
        tick();
        req1_valid = 1'b0;
        check_eq("t3_rsv_ready_after", 32'(rsv_ready), 32'd1);
        check_eq("t3_hazard_cnt2",     32'(hazard1),   32'd1);
        req0_valid = 1'b1; req0_a = 5'd7; req0_data = 32'h0000_0778;
        tick();
        check_eq("t3_hazard_cnt1", 32'(hazard1), 32'd1);
        tick();
        req0_valid = 1'b0;
        check_eq("t3_hazard_cnt0", 32'(hazard1), 32'd0);
        check_eq("t3_sb_err",      32'(sb_err),  32'd0);

        // Same-cycle reserve and release of R9 nets to zero change.
        chk_a1 = 5'd9;
        reserve(5'd9);
        rsv_valid = 1'b1; rsv_a = 5'd9;
        req0_valid = 1'b1; req0_a = 5'd9; req0_data = 32'h0000_0999;
        #1;
        check_eq("t4_rsv_ready",  32'(rsv_ready),  32'd1);
        check_eq("t4_req0_ready", 32'(req0_ready), 32'd1);
        tick();
        rsv_valid = 1'b0;
        req0_valid = 1'b0;
        check_eq("t4_hazard_held", 32'(hazard1), 32'd1);
        req1_valid = 1'b1; req1_a = 5'd9; req1_data = 32'h0000_099A;
        tick();
        req1_valid = 1'b0;
        check_eq("t4_hazard_clear", 32'(hazard1), 32'd0);
        check_eq("t4_sb_err",       32'(sb_err),  32'd0);

        // R0 reservation is a no-op.
        rsv_valid = 1'b1; rsv_a = 5'd0; chk_a1 = 5'd0;
        #1;
        check_eq("t5_rsv_r0_ready", 32'(rsv_ready), 32'd1);
        tick();
        rsv_valid = 1'b0;
        check_eq("t5_hazard_r0", 32'(hazard1), 32'd0);

        // Write to R0 is dropped; write to unreserved R12 sets the sticky error.
        req1_valid = 1'b1; req1_a = 5'd0; req1_data = 32'h0000_1234;
        #1;
        check_eq("t5_req1_ready_r0", 32'(req1_ready), 32'd1);
        tick();
        req1_valid = 1'b0;
        check_eq("t5_write_en_r0", 32'(write_en), 32'd0);
        check_eq("t5_sb_err_r0",   32'(sb_err),   32'd0);
        chk_a2 = 5'd12;
        req0_valid = 1'b1; req0_a = 5'd12; req0_data = 32'h0000_C0DE;
        tick();
        req0_valid = 1'b0;
        check_eq("t5_write_en_r12", 32'(write_en), 32'd1);
        check_eq("t5_write_a_r12",  32'(write_a),  32'd12);
        check_eq("t5_sb_err_set",   32'(sb_err),   32'd1);
        tick();
        tick();
        check_eq("t5_sb_err_sticky", 32'(sb_err),  32'd1);
        check_eq("t5_hazard_r12",    32'(hazard2), 32'd0);

        // Reset mid-burst: everything clears without a clock edge.
        reserve(5'd3); reserve(5'd4); reserve(5'd4);
        chk_a1 = 5'd3; chk_a2 = 5'd4;
        req0_valid = 1'b1; req0_a = 5'd3; req0_data = 32'h3333_0003;
        req1_valid = 1'b1; req1_a = 5'd4; req1_data = 32'h4444_0004;
        tick();
        // req0 won last (R12), so req1 goes first.
        check_eq("t6_write_en_pre", 32'(write_en), 32'd1);
        check_eq("t6_write_a_pre",  32'(write_a),  32'd4);
        check_eq("t6_hazard1_pre",  32'(hazard1),  32'd1);
        check_eq("t6_hazard2_pre",  32'(hazard2),  32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_write_en",   32'(write_en), 32'd0);
        check_eq("t6_rst_write_a",    32'(write_a),  32'd0);
        check_eq("t6_rst_write_data", write_data,    32'd0);
        check_eq("t6_rst_sb_err",     32'(sb_err),   32'd0);
        check_eq("t6_rst_hazard1",    32'(hazard1),  32'd0);
        check_eq("t6_rst_hazard2",    32'(hazard2),  32'd0);
        #1;
        rst_n = 1'b1;
        #1;
        check_eq("t6_tie_req0_ready", 32'(req0_ready), 32'd1);
        check_eq("t6_tie_req1_ready", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        check_eq("t6_post_write_a",  32'(write_a),  32'd3);
        check_eq("t6_post_write_en", 32'(write_en), 32'd1);
        check_eq("t6_post_sb_err",   32'(sb_err),   32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: req0 = ALU pipe, req1 = multi-cycle mul/div/load unit.
- Also keeps a per-register pending-write scoreboard. Issue logic uses it to detect RAW hazards on the two read addresses.
- Sits between the execute/writeback units and the register file; its registered outputs drive the register file's write_en / write_a / write_data.

Parameters:
- NREG, 32, number of architectural registers (R0 hardwired zero).
- AW, 5, register address width.
- DW, 32, data width.
- CW, 2, width of each pending-write counter; saturates at 2^CW-1.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  ALU writeback request.
- req0_ready  out  1  req0 accepted this cycle.
- req0_a  in  AW  destination register.
- req0_data  in  DW  write value.
- req1_valid  in  1  mul/div/load writeback request.
- req1_ready  out  1  req1 accepted this cycle.
- req1_a  in  AW  destination register.
- req1_data  in  DW  write value.
- rsv_valid  in  1  issue stage reserves a destination register.
- rsv_ready  out  1  reservation accepted.
- rsv_a  in  AW  register being reserved.
- chk_a1  in  AW  read address 1 to check.
- chk_a2  in  AW  read address 2 to check.
- hazard1  out  1  chk_a1 has a pending write.
- hazard2  out  1  chk_a2 has a pending write.
- write_en  out  1  to register file.
- write_a  out  AW  to register file.
- write_data  out  DW  to register file.
- sb_err  out  1  sticky: writeback to a register with no pending reservation.

Behaviour:
- Reset (rst_n low, async):
  - write_en=0, write_a=0, write_data=0, sb_err=0.
  - All counters 0; last_grant=1, so req0 wins the first tie.
- Arbitration (combinational ready, one grant per cycle):
  - Only one valid: it is granted.
  - Both valid: grant the requester not equal to last_grant.
  - No valid: no grant; last_grant unchanged.
  - Handshake: transfer on valid&&ready at the rising edge. A requester not granted must hold valid, addr and data stable. Ready never depends on the requester's own ready.
- Write port (latency 1):
  - On a grant edge, register write_a/write_data from the winner and set write_en=1.
  - If the winner's address is 0, write_en=0: the request is consumed and dropped.
  - No grant: write_en=0; write_a/write_data hold their previous values.
  - The register file commits on the following falling edge.
- Scoreboard: one CW-bit counter per register 1..NREG-1; R0 counter is constant 0.
  - rsv_ready = (cnt[rsv_a] != 2^CW-1). No look-ahead on a same-cycle decrement.
  - Reserve accepted (rsv_valid&&rsv_ready, rsv_a!=0): +1.
  - Granted writeback to register a (a!=0): -1 at the grant edge. The consumer may read in the next cycle; data is present after that cycle's falling edge.
  - Reserve and grant on the same register in the same cycle: net 0.
  - Reserve of R0: rsv_ready=1, no effect.
  - Grant to a register whose counter is 0: counter stays 0, sb_err set until reset; the write still proceeds.
- Hazard outputs: hazardN = (chk_aN != 0) && (cnt[chk_aN] != 0). Purely combinational from current counter state, no same-cycle bypass.
- Reset mid-operation: all in-flight state discarded, including any write_en asserted in that cycle. Requesters must re-present after rst_n deasserts.

Decomposition:
- Shared package rf_pkg: AW, DW, NREG constants; REG_ZERO constant.
- Sub-module rf_scoreboard: counter array, rsv_ready, hazard1/2, sb_err. Inputs are reserve (valid, a) and release (valid, a).
- Arbiter and write-port registers stay in rf_wb_arbiter.

Test Plan:
- Reset, then req0 only (a=5, data=0xDEADBEEF) with R5 reserved → req0_ready=1 same cycle; next cycle write_en=1, write_a=5, write_data=0xDEADBEEF; hazard on R5 clears after the grant edge.
- req0 and req1 both valid, held for 4 cycles (a=3 and a=4, both reserved) → grants alternate req0, req1, req0, req1; write_en stays high each cycle.
- Reserve R7 three times (CW=2) → rsv_ready=0 on a fourth attempt; one writeback to R7 → rsv_ready=1 and counter=2, hazard1 still 1 with chk_a1=7.
- Same-cycle reserve of R9 and granted writeback to R9 with counter=1 → counter remains 1 and hazard stays high.
- req1 writes R0 (data=0x1234) → req1_ready=1, write_en=0 next cycle, sb_err stays 0. Then req0 writes unreserved R12 → write_en=1 and sb_err=1, held until reset.
- Assert rst_n low mid-burst while write_en=1 → write_en, write_a, write_data, sb_err and all hazards go 0 immediately without a clock edge; after release, req0 wins the first tie.
